execute_stage: RTL and testbench
================================

# execute_stage

Execute stage of the 16-bit datapath, directly downstream of the A/B operand registers. Selects and shifts operands, performs ADD/SUB/AND/MVN in one cycle or an unsigned shift-add MUL over WIDTH cycles, and writes the result register C and the Z/N/V status register. A start/busy/done handshake reports completion to the controller FSM.

## Interface
- WIDTH, 16, datapath width; also the MUL iteration count
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; one clock, asynchronous active-high reset as stated
- A  in  WIDTH  operand from the A register
- B  in  WIDTH  operand from the B register
- sximm5  in  WIDTH  sign-extended immediate
- asel  in  1  1: Ain = 0; 0: Ain = A
- bsel  in  1  1: Bin = sximm5; 0: Bin = shifted B
- shift  in  2  00 none, 01 LSL1, 10 LSR1 (zero fill), 11 ASR1 (msb fill)
- ALUop  in  3  000 ADD, 001 SUB, 010 AND, 011 MVN (~Bin), 100 MUL, 101–111 reserved
- loadc  in  1  write C at completion
- loads  in  1  write status at completion
- start  in  1  begin operation; sampled only in IDLE
- busy  out  1  high while in MUL
- done  out  1  one-cycle completion pulse
- C  out  WIDTH  result register
- status  out  3  {V, N, Z}

## Operation
- States: IDLE, MUL.
- IDLE, start=1, ALUop≠100: compute Ain op Bin combinationally. At that edge write C if loadc and status if loads, set done=1 for the next cycle, and stay in IDLE.
- IDLE, start=1, ALUop=100: latch Ain (multiplicand), Bin (multiplier), loadc and loads. Clear the accumulator, set cnt=WIDTH, go to MUL.
- MUL, each edge: if multiplier[0], acc += multiplicand (mod 2^WIDTH); multiplicand <<= 1; multiplier >>= 1; cnt--.
- MUL, edge where cnt goes 1→0: write the final acc to C if latched loadc, and status if latched loads. Set done=1 and go to IDLE.
- MUL uses operands latched at start; A, B, shift, asel, bsel and ALUop may change freely while busy.
- start while busy: ignored, with no queueing.
- Reserved ALUop: result 0, completes as a single-cycle op; Z=1 if loads.
- Arithmetic is modulo 2^WIDTH. SUB = Ain + ~Bin + 1.
- Z = (result == 0); N = result[WIDTH-1].
- V (see Configuration): signed overflow for ADD/SUB; 0 for AND, MVN, MUL and reserved.
- Reset at any time, including mid-MUL: abort, state=IDLE, C=0, status=000, busy=0, done=0, accumulator/counter cleared.

## Timing
- Single-cycle op: start sampled at edge k. C/status are valid after edge k. done is high for cycle k..k+1. Latency 1.
- MUL: start at edge k. busy is high after edge k through edge k+WIDTH. C/status are written at edge k+WIDTH. done is high for the cycle after edge k+WIDTH. Latency WIDTH (16).
- done and busy are never high together.
- start may be asserted in the cycle done is high; it is accepted, giving back-to-back operations.
- C and status hold their value whenever not written.

## Configuration
- STATUS_V_EN defined: V computed as specified. For ADD, V = (Ain[msb]==Bin[msb]) && (res[msb]!=Ain[msb]). For SUB, the same test with ~Bin.
- STATUS_V_EN undefined: no overflow logic; status[2] is tied to 0 and the port width is unchanged.

## Structure
- Shared package exec_pkg holds:
  - ALUop codes (ALU_ADD, ALU_SUB, ALU_AND, ALU_MVN, ALU_MUL)
  - shift codes (SH_NONE, SH_LSL, SH_LSR, SH_ASR)
  - the state enum {S_IDLE, S_MUL}
  - status bit indices (ST_Z=0, ST_N=1, ST_V=2)
- One combinational sub-module, exec_shifter (WIDTH, in, shift → out). The ALU, FSM and multiplier stay in execute_stage.

## Test plan
- ADD, 1 cycle: A=0x0005, B=0x0003, shift=00, asel=bsel=0, loadc=loads=1, start → next cycle C=0x0008, status=000, done=1, busy=0.
- SUB overflow (with STATUS_V_EN): A=0x8000, B=0x0001 → C=0x7FFF, status=100. Without the macro → status=000.
- Shift/immediate:
  - B=0x8001, shift=11, ALUop=MVN → C=~0xC000=0x3FFF.
  - bsel=1, sximm5=0xFFF0, asel=1, ADD → C=0xFFF0, N=1.
- MUL: A=0x0012, B=0x0034, start → busy high for exactly 16 cycles, then done pulse with C=0x03A8, status=000. A/B are changed to 0 mid-operation with no effect. A second start while busy is ignored.
- Reset mid-MUL at cycle 7 → C=0, status=0, busy=0, done stays 0. A following ADD completes normally in 1 cycle.
- Back-to-back: start a MUL, then assert start with AND (0x00FF & 0x0F0F) in the done cycle → C=0x000F one cycle later. Also, with loadc=0, C keeps its previous value while done still pulses.

Source files
------------

// File: rtl/exec_pkg.sv
// Shared encodings for the execute stage: ALU opcodes, shifter codes,
// controller states and status-register bit positions.
package exec_pkg;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_MVN = 3'b011,
        ALU_MUL = 3'b100
    } alu_op_e;

    typedef enum logic [1:0] {
        SH_NONE = 2'b00,
        SH_LSL  = 2'b01,
        SH_LSR  = 2'b10,
        SH_ASR  = 2'b11
    } shift_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_MUL  = 1'b1
    } state_e;

    localparam int ST_Z = 0;
    localparam int ST_N = 1;
    localparam int ST_V = 2;

endpackage

// File: rtl/execute_stage_if.sv
// Operand/control/result bundle between the controller (master) and the
// execute stage (slave).
interface execute_stage_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] sximm5;
    logic             asel;
    logic             bsel;
    logic [1:0]       shift;
    logic [2:0]       ALUop;
    logic             loadc;
    logic             loads;
    logic             start;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] C;
    logic [2:0]       status;

    modport master (
        output A, B, sximm5, asel, bsel, shift, ALUop, loadc, loads, start,
        input  busy, done, C, status
    );

    modport slave (
        input  A, B, sximm5, asel, bsel, shift, ALUop, loadc, loads, start,
        output busy, done, C, status
    );
endinterface

// File: rtl/exec_shifter.sv
// Combinational one-position shifter applied to the B operand.
module exec_shifter
    import exec_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] in,
    input  logic [1:0]       shift,
    output logic [WIDTH-1:0] out
);
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path
        // through the case can leave it unassigned and infer a latch.
        out = in;
        case (shift)
            SH_LSL:  out = {in[WIDTH-2:0], 1'b0};
            SH_LSR:  out = {1'b0, in[WIDTH-1:1]};
            SH_ASR:  out = {in[WIDTH-1], in[WIDTH-1:1]};
            default: out = in;
        endcase
    end
endmodule

// File: rtl/execute_stage.sv
// Execute stage: single-cycle ADD/SUB/AND/MVN plus a WIDTH-cycle shift-add MUL.
// Define STATUS_V_EN to build the signed-overflow (V) status logic.
module execute_stage
    import exec_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic          clk,
    input  logic          reset,
    execute_stage_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] b_shifted, ain, bin, b_eff, alu_res, acc_next;
    logic             alu_v;

    state_e           state;
    logic [WIDTH-1:0] mcand, mplier, acc;
    logic [CNT_W-1:0] cnt;
    logic             lat_loadc, lat_loads;
    logic [WIDTH-1:0] c_reg;
    logic [2:0]       status_reg;
    logic             busy_reg, done_reg;

    function automatic logic [2:0] flags(input logic [WIDTH-1:0] r, input logic v);
        logic [2:0] st;
        st       = '0;
        st[ST_Z] = (r == '0);
        st[ST_N] = r[WIDTH-1];
        st[ST_V] = v;
        return st;
    endfunction

    exec_shifter #(.WIDTH(WIDTH)) u_shifter (
        .in    (bus.B),
        .shift (bus.shift),
        .out   (b_shifted)
    );

    assign ain = bus.asel ? '0 : bus.A;
    assign bin = bus.bsel ? bus.sximm5 : b_shifted;

    always_comb begin
        alu_res = '0;
        b_eff   = bin;
        alu_v   = 1'b0;
        case (bus.ALUop)
            ALU_ADD: alu_res = ain + bin;
            ALU_SUB: begin
                b_eff   = ~bin;
                alu_res = ain + b_eff + WIDTH'(1);
            end
            ALU_AND: alu_res = ain & bin;
            ALU_MVN: alu_res = ~bin;
            default: alu_res = '0;
        endcase
`ifdef STATUS_V_EN
        if (bus.ALUop == ALU_ADD || bus.ALUop == ALU_SUB)
            alu_v = (ain[WIDTH-1] == b_eff[WIDTH-1]) && (alu_res[WIDTH-1] != ain[WIDTH-1]);
`endif
    end

    assign acc_next = mplier[0] ? acc + mcand : acc;

    // NOTE: sequential state uses non-blocking assignments only, and every
    // register (datapath included) is cleared so reset aborts a MUL cleanly.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            mcand      <= '0;
            mplier     <= '0;
            acc        <= '0;
            cnt        <= '0;
            lat_loadc  <= 1'b0;
            lat_loads  <= 1'b0;
            c_reg      <= '0;
            status_reg <= '0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        if (bus.ALUop == ALU_MUL) begin
                            mcand     <= ain;
                            mplier    <= bin;
                            lat_loadc <= bus.loadc;
                            lat_loads <= bus.loads;
                            acc       <= '0;
                            cnt       <= CNT_W'(WIDTH);
                            busy_reg  <= 1'b1;
                            state     <= S_MUL;
                        end else begin
                            if (bus.loadc) c_reg      <= alu_res;
                            if (bus.loads) status_reg <= flags(alu_res, alu_v);
                            done_reg <= 1'b1;
                        end
                    end
                end
                S_MUL: begin
                    acc    <= acc_next;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt - CNT_W'(1);
                    // Last iteration: commit the accumulator including this step's add.
                    if (cnt == CNT_W'(1)) begin
                        if (lat_loadc) c_reg      <= acc_next;
                        if (lat_loads) status_reg <= flags(acc_next, 1'b0);
                        done_reg <= 1'b1;
                        busy_reg <= 1'b0;
                        state    <= S_IDLE;
                    end
                end
            endcase
        end
    end

    assign bus.C      = c_reg;
    assign bus.status = status_reg;
    assign bus.busy   = busy_reg;
    assign bus.done   = done_reg;
endmodule

// File: tb/tb_execute_stage.sv
// Directed, scoreboarded bench for execute_stage (honours STATUS_V_EN).
module tb_execute_stage;
    localparam int WIDTH = 16;

    typedef struct {
        logic [15:0] c;
        logic [2:0]  st;
    } exp_t;

    logic clk;
    logic reset;
    int   compared   = 0;
    int   mismatched = 0;
    exp_t sb[$];
    logic [15:0] model_c  = '0;
    logic [2:0]  model_st = '0;

    execute_stage_if #(.WIDTH(WIDTH)) bus ();

    execute_stage #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one operation, predict its effect on C/status, push it, pulse start.
    task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic [15:0] sx,
                         input logic as, input logic bs, input logic [1:0] sh,
                         input logic [2:0] op, input logic lc, input logic ls);
        logic [15:0] ain, bsh, bin, res;
        logic [31:0] prod;
        int          sr;
        logic        v;
        exp_t        e;
        bus.A = a; bus.B = b; bus.sximm5 = sx; bus.asel = as; bus.bsel = bs;
        bus.shift = sh; bus.ALUop = op; bus.loadc = lc; bus.loads = ls;
        ain = as ? 16'h0000 : a;
        case (sh)
            2'b01:   bsh = b << 1;
            2'b10:   bsh = b >> 1;
            2'b11:   bsh = 16'($signed(b) >>> 1);
            default: bsh = b;
        endcase
        bin = bs ? sx : bsh;
        v   = 1'b0;
        case (op)
            3'b000: begin
                res = ain + bin;
                sr  = int'($signed(ain)) + int'($signed(bin));
                v   = (sr > 32767) || (sr < -32768);
            end
            3'b001: begin
                res = ain - bin;
                sr  = int'($signed(ain)) - int'($signed(bin));
                v   = (sr > 32767) || (sr < -32768);
            end
            3'b010: res = ain & bin;
            3'b011: res = ~bin;
            3'b100: begin
                prod = ain * bin;
                res  = prod[15:0];
            end
            default: res = 16'h0000;
        endcase
`ifndef STATUS_V_EN
        v = 1'b0;
`endif
        if (lc) model_c = res;
        if (ls) model_st = {v, res[15], res == 16'h0000};
        e.c  = model_c;
        e.st = model_st;
        sb.push_back(e);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic expect_result(input string tag);
        exp_t e;
        check({tag, "_sb_nonempty"}, 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check({tag, "_C"}, 32'(bus.C), 32'(e.c));
            check({tag, "_status"}, 32'(bus.status), 32'(e.st));
        end
    endtask

    // Wait (bounded) for done; lat counts edges after the start edge.
    // At edge offset poke_at, operands are zeroed and a stray start is pulsed.
    task automatic run_until_done(input string tag, input int exp_lat, input int poke_at);
        int lat      = 0;
        int busy_cnt = 0;
        while (!bus.done && lat < 40) begin
            if (bus.busy) busy_cnt++;
            if (lat == poke_at) begin
                bus.A = '0; bus.B = '0; bus.ALUop = 3'b000; bus.start = 1'b1;
            end else begin
                bus.start = 1'b0;
            end
            tick();
            lat++;
        end
        bus.start = 1'b0;
        check({tag, "_done"}, 32'(bus.done), 32'd1);
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(exp_lat));
        check({tag, "_busy_at_done"}, 32'(bus.busy), 32'd0);
        expect_result(tag);
    endtask

    initial begin
        bus.A = '0; bus.B = '0; bus.sximm5 = '0; bus.asel = 1'b0; bus.bsel = 1'b0;
        bus.shift = 2'b00; bus.ALUop = 3'b000; bus.loadc = 1'b0; bus.loads = 1'b0;
        bus.start = 1'b0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_C", 32'(bus.C), 32'd0);
        check("rst_status", 32'(bus.status), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        reset = 1'b0;
        tick();

        // Single-cycle ops
        issue(16'h0005, 16'h0003, 16'h0000, 1'b0, 1'b0, 2'b00, 3'b000, 1'b1, 1'b1);
        run_until_done("add", 0, -1);
        check("add_C_const", 32'(bus.C), 32'h0008);
        tick();
        check("add_done_one_cycle", 32'(bus.done), 32'd0);

        issue(16'h8000, 16'h0001, 16'h0000, 1'b0, 1'b0, 2'b00, 3'b001, 1'b1, 1'b1);
        run_until_done("sub_ovf", 0, -1);
        issue(16'h7FFF, 16'h0001, 16'h0000, 1'b0, 1'b0, 2'b00, 3'b000, 1'b1, 1'b1);
        run_until_done("add_ovf", 0, -1);
        issue(16'h1234, 16'h8001, 16'h0000, 1'b0, 1'b0, 2'b11, 3'b011, 1'b1, 1'b1);
        run_until_done("mvn_asr", 0, -1);
        check("mvn_asr_const", 32'(bus.C), 32'h3FFF);
        issue(16'h5555, 16'h0000, 16'hFFF0, 1'b1, 1'b1, 2'b00, 3'b000, 1'b1, 1'b1);
        run_until_done("imm_add", 0, -1);
        issue(16'h0001, 16'h8001, 16'h0000, 1'b0, 1'b0, 2'b10, 3'b000, 1'b1, 1'b1);
        run_until_done("lsr_add", 0, -1);
        issue(16'hFFFF, 16'h4001, 16'h0000, 1'b0, 1'b0, 2'b01, 3'b010, 1'b1, 1'b1);
        run_until_done("lsl_and", 0, -1);
        issue(16'h1111, 16'h2222, 16'h0000, 1'b0, 1'b0, 2'b00, 3'b101, 1'b1, 1'b1);
        run_until_done("reserved", 0, -1);

        // MUL with operand changes and an ignored start while busy
        issue(16'h0012, 16'h0034, 16'h0000, 1'b0, 1'b0, 2'b00, 3'b100, 1'b1, 1'b1);
        run_until_done("mul", 16, 4);
        check("mul_C_const", 32'(bus.C), 32'h03A8);
        tick();
        check("mul_no_queued_op", 32'(bus.done), 32'd0);
        check("mul_C_held", 32'(bus.C), 32'h03A8);

        issue(16'h0100, 16'h0100, 16'h0000, 1'b0, 1'b0, 2'b00, 3'b100, 1'b1, 1'b1);
        run_until_done("mul_wrap", 16, -1);

        // Reset in the middle of a MUL
        issue(16'h0003, 16'h0005, 16'h0000, 1'b0, 1'b0, 2'b00, 3'b100, 1'b1, 1'b1);
        repeat (6) tick();
        check("mid_busy", 32'(bus.busy), 32'd1);
        reset = 1'b1;
        #1;
        check("mid_rst_C", 32'(bus.C), 32'd0);
        check("mid_rst_status", 32'(bus.status), 32'd0);
        check("mid_rst_busy", 32'(bus.busy), 32'd0);
        check("mid_rst_done", 32'(bus.done), 32'd0);
        sb.delete();
        model_c  = '0;
        model_st = '0;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            check("post_rst_no_done", 32'(bus.done | bus.busy), 32'd0);
        end
        issue(16'h0007, 16'h0009, 16'h0000, 1'b0, 1'b0, 2'b00, 3'b000, 1'b1, 1'b1);
        run_until_done("post_rst_add", 0, -1);

        // Back-to-back: AND started in the MUL's done cycle
        issue(16'h0002, 16'h0003, 16'h0000, 1'b0, 1'b0, 2'b00, 3'b100, 1'b1, 1'b1);
        run_until_done("b2b_mul", 16, -1);
        issue(16'h00FF, 16'h0F0F, 16'h0000, 1'b0, 1'b0, 2'b00, 3'b010, 1'b1, 1'b1);
        run_until_done("b2b_and", 0, -1);
        check("b2b_and_const", 32'(bus.C), 32'h000F);

        // loadc=0: C holds while done still pulses and status updates
        issue(16'h0001, 16'h0001, 16'h0000, 1'b0, 1'b0, 2'b00, 3'b000, 1'b0, 1'b1);
        run_until_done("noloadc", 0, -1);
        check("noloadc_C_const", 32'(bus.C), 32'h000F);

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
